// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard-unit state encoding and register-file constants.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } hazard_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones, clears on reset.
module sat_counter #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [COUNT_W-1:0] q
);

  logic [COUNT_W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard controller: load-use stalls, taken-branch flushes, memory-wait freezes.
// Optional perf counters (StallCount/FlushCount) are built when HAZARD_PERF_EN is defined.
module hazard_detection_unit
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int COUNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [REG_W-1:0]   IF_ID_RegisterRs,
  input  logic [REG_W-1:0]   IF_ID_RegisterRt,
  input  logic               IF_ID_UsesRt,
  input  logic               ID_EX_MemRead,
  input  logic [REG_W-1:0]   ID_EX_RegisterRt,
  input  logic               EX_BranchTaken,
  input  logic               MEM_Busy,
  output logic               PCWrite,
  output logic               IF_ID_Write,
  output logic               IF_ID_Flush,
  output logic               ID_EX_Bubble,
`ifdef HAZARD_PERF_EN
  output logic               PipeFreeze,
  output logic [COUNT_W-1:0] StallCount,
  output logic [COUNT_W-1:0] FlushCount
`else
  output logic               PipeFreeze
`endif
);

  localparam logic [2:0] LU_REM = 3'(LOAD_STALL_CYCLES - 1);

  hazard_state_e r_state;
  hazard_state_e w_next_state;
  logic [2:0]    r_rem;
  logic [2:0]    w_next_rem;

  logic w_lu;
  logic w_pc;
  logic w_ifid;
  logic w_flush;
  logic w_bub;
  logic w_frz;

  assign w_lu = ID_EX_MemRead && (ID_EX_RegisterRt != REG_ZERO) &&
                ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                 (IF_ID_UsesRt && (ID_EX_RegisterRt == IF_ID_RegisterRt)));

  always_comb begin
    w_pc         = 1'b1;
    w_ifid       = 1'b1;
    w_flush      = 1'b0;
    w_bub        = 1'b0;
    w_frz        = 1'b0;
    w_next_state = r_state;
    w_next_rem   = r_rem;
    if (MEM_Busy) begin
      w_pc   = 1'b0;
      w_ifid = 1'b0;
      w_frz  = 1'b1;
    end else if (r_state == LU_STALL) begin
      // EX holds a bubble here, so neither branch nor lu can be meaningful
      w_pc   = 1'b0;
      w_ifid = 1'b0;
      w_bub  = 1'b1;
      w_next_rem = r_rem - 3'd1;
      if (r_rem <= 3'd1) begin
        w_next_state = RUN;
        w_next_rem   = 3'd0;
      end
    end else if (EX_BranchTaken) begin
      w_flush = 1'b1;
      w_bub   = 1'b1;
      w_next_state = RUN;
    end else if (w_lu) begin
      w_pc   = 1'b0;
      w_ifid = 1'b0;
      w_bub  = 1'b1;
      if (LOAD_STALL_CYCLES > 1) begin
        w_next_state = LU_STALL;
        w_next_rem   = LU_REM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_rem   <= 3'd0;
    end else begin
      r_state <= w_next_state;
      r_rem   <= w_next_rem;
    end
  end

  // Controls are forced low for as long as reset is held
  assign PCWrite      = rst_n & w_pc;
  assign IF_ID_Write  = rst_n & w_ifid;
  assign IF_ID_Flush  = rst_n & w_flush;
  assign ID_EX_Bubble = rst_n & w_bub;
  assign PipeFreeze   = rst_n & w_frz;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n && !MEM_Busy && (r_state == LU_STALL)) begin
      assert (!EX_BranchTaken);
    end
  end
`endif

`ifdef HAZARD_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = !MEM_Busy && w_bub && !w_flush;
  assign w_flush_inc = !MEM_Busy && w_flush;

  sat_counter #(.COUNT_W(COUNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_stall_inc),
    .q     (StallCount)
  );

  sat_counter #(.COUNT_W(COUNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_flush_inc),
    .q     (FlushCount)
  );
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (COUNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed bench for hazard_detection_unit: one instance with single-cycle and one with
// three-cycle load-use stalls, driven from shared inputs.
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, exrt;
  logic       uses_rt, memrd, br, busy;

  logic pc1, ifid1, fl1, bub1, frz1;
  logic pc3, ifid3, fl3, bub3, frz3;
  logic [4:0] o1, o3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
  logic [3:0] sc1, fc1, sc3, fc3;
`endif

  hazard_detection_unit #(.LOAD_STALL_CYCLES(1), .COUNT_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses_rt),
    .ID_EX_MemRead(memrd), .ID_EX_RegisterRt(exrt),
    .EX_BranchTaken(br), .MEM_Busy(busy),
    .PCWrite(pc1), .IF_ID_Write(ifid1), .IF_ID_Flush(fl1), .ID_EX_Bubble(bub1),
`ifdef HAZARD_PERF_EN
    .PipeFreeze(frz1), .StallCount(sc1), .FlushCount(fc1)
`else
    .PipeFreeze(frz1)
`endif
  );

  hazard_detection_unit #(.LOAD_STALL_CYCLES(3), .COUNT_W(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_RegisterRs(rs), .IF_ID_RegisterRt(rt), .IF_ID_UsesRt(uses_rt),
    .ID_EX_MemRead(memrd), .ID_EX_RegisterRt(exrt),
    .EX_BranchTaken(br), .MEM_Busy(busy),
    .PCWrite(pc3), .IF_ID_Write(ifid3), .IF_ID_Flush(fl3), .ID_EX_Bubble(bub3),
`ifdef HAZARD_PERF_EN
    .PipeFreeze(frz3), .StallCount(sc3), .FlushCount(fc3)
`else
    .PipeFreeze(frz3)
`endif
  );

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PipeFreeze}
  assign o1 = {pc1, ifid1, fl1, bub1, frz1};
  assign o3 = {pc3, ifid3, fl3, bub3, frz3};

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkc(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_uses,
                        input logic i_mrd, input logic [4:0] i_exrt, input logic i_br,
                        input logic i_busy);
    rs = i_rs; rt = i_rt; uses_rt = i_uses; memrd = i_mrd; exrt = i_exrt;
    br = i_br; busy = i_busy;
  endtask

  task automatic clear_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_in();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    #1;
    chk("reset_dut1", o1, 5'b00000);
    chk("reset_dut3", o3, 5'b00000);
`ifdef HAZARD_PERF_EN
    chkc("reset_stallcnt", sc1, 4'd0);
    chkc("reset_flushcnt", fc1, 4'd0);
`endif
    next_cycle();
    rst_n = 1'b1;
    clear_in();
    #1;
    chk("idle_dut1", o1, 5'b11000);

    // Load-use on rs: lw r2 in EX, ID reads r2
    next_cycle();
    set_in(5'd2, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    #1;
    chk("lu_rs_dut1", o1, 5'b00010);
    chk("lu_rs_dut3_c0", o3, 5'b00010);
    next_cycle();
    clear_in();
    #1;
    chk("lu_rs_after_dut1", o1, 5'b11000);
    chk("lu_rs_dut3_c1", o3, 5'b00010);
    next_cycle();
    #1;
    chk("lu_rs_dut3_c2", o3, 5'b00010);
    next_cycle();
    #1;
    chk("lu_rs_dut3_done", o3, 5'b11000);

    // Load into r0 never stalls
    next_cycle();
    set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    chk("lu_r0_dut1", o1, 5'b11000);
    chk("lu_r0_dut3", o3, 5'b11000);

    // rt match only counts when rt is a source
    next_cycle();
    set_in(5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    chk("lu_rt_unused", o1, 5'b11000);
    next_cycle();
    set_in(5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0);
    #1;
    chk("lu_rt_used", o1, 5'b00010);

    // Three-cycle stall interrupted by a two-cycle memory wait
    do_reset();
    set_in(5'd7, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0);
    #1;
    chk("frz_t0_dut3", o3, 5'b00010);
    chk("frz_t0_dut1", o1, 5'b00010);
    next_cycle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    #1;
    chk("frz_t1_dut3", o3, 5'b00001);
    chk("frz_t1_dut1", o1, 5'b00001);
    next_cycle();
    #1;
    chk("frz_t2_dut3", o3, 5'b00001);
    next_cycle();
    clear_in();
    #1;
    chk("frz_t3_dut3", o3, 5'b00010);
    chk("frz_t3_dut1", o1, 5'b11000);
    next_cycle();
    #1;
    chk("frz_t4_dut3", o3, 5'b00010);
    next_cycle();
    #1;
    chk("frz_t5_dut3", o3, 5'b11000);
`ifdef HAZARD_PERF_EN
    chkc("frz_stallcnt_dut3", sc3, 4'd3);
    chkc("frz_stallcnt_dut1", sc1, 4'd1);
    chkc("frz_flushcnt_dut3", fc3, 4'd0);
`endif

    // Taken branch coinciding with a load-use: flush wins, no stall entry
    do_reset();
    set_in(5'd3, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0);
    #1;
    chk("br_lu_dut1", o1, 5'b11110);
    chk("br_lu_dut3", o3, 5'b11110);
    next_cycle();
    clear_in();
    #1;
    chk("br_after_dut3", o3, 5'b11000);
`ifdef HAZARD_PERF_EN
    chkc("br_flushcnt", fc3, 4'd1);
    chkc("br_stallcnt", sc3, 4'd0);
`endif

    // Reset in the middle of a load-use stall
    do_reset();
    set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0);
    #1;
    chk("rst_lu_t0", o3, 5'b00010);
    next_cycle();
    clear_in();
    #1;
    chk("rst_lu_t1", o3, 5'b00010);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_dut3", o3, 5'b00000);
    chk("rst_mid_dut1", o1, 5'b00000);
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("rst_release", o3, 5'b11000);
    next_cycle();
    #1;
    chk("rst_release_next", o3, 5'b11000);

`ifdef HAZARD_PERF_EN
    // Continuous load-use: counter saturates at 15 with COUNT_W=4
    do_reset();
    set_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0);
    repeat (10) next_cycle();
    #1;
    chkc("sat_stall_10", sc1, 4'd10);
    repeat (10) next_cycle();
    #1;
    chkc("sat_stall_20", sc1, 4'd15);
    chkc("sat_stall_20_dut3", sc3, 4'd15);
    clear_in();
`endif

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
